// File: rtl/mxv_scheduler_if.sv
// mxv_scheduler_if: job control, operand memory, processor and result-port signals of the scheduler.
interface mxv_scheduler_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int SW = $clog2(N + 1);
  localparam int AW = $clog2(N * N);
  localparam int CW = $clog2(N);
  logic          start;
  logic [SW-1:0] size;
  logic          err;
  logic          busy;
  logic          done;
  logic [AW-1:0] mat_addr;
  logic [DW-1:0] mat_data;
  logic [CW-1:0] vec_addr;
  logic [DW-1:0] vec_data;
  logic          proc_enable;
  logic          proc_retro;
  logic [DW-1:0] proc_A;
  logic [DW-1:0] proc_B;
  logic [DW-1:0] proc_prev;
  logic [DW-1:0] proc_out;
  logic          proc_done;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [CW-1:0] res_row;
  modport master (
    input  start, size, mat_data, vec_data, proc_out, proc_done, res_ready,
    output err, busy, done, mat_addr, vec_addr, proc_enable, proc_retro,
           proc_A, proc_B, proc_prev, res_valid, res_data, res_row
  );
  modport slave (
    output start, size, mat_data, vec_data, proc_out, proc_done, res_ready,
    input  err, busy, done, mat_addr, vec_addr, proc_enable, proc_retro,
           proc_A, proc_B, proc_prev, res_valid, res_data, res_row
  );
endinterface

// File: rtl/mxv_scheduler.sv
// mxv_scheduler: sequences row-by-row MAC operations of a processor to compute y = M*v.
module mxv_scheduler #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input logic           clk,
  input logic           rst,
  mxv_scheduler_if.master bus
);
  localparam int SW = $clog2(N + 1);
  localparam int AW = $clog2(N * N);
  localparam int CW = $clog2(N);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [SW-1:0] n_q, n_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d, res_row_q, res_row_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d, done_q, done_d, err_q, err_d;
  logic          en_q, retro_q;
  logic          size_ok, last_col, last_row, run;
  assign size_ok  = bus.size != '0 && bus.size <= SW'(N);
  assign last_col = SW'(col_q) == n_q - 1'b1;
  assign last_row = SW'(row_q) == n_q - 1'b1;
  assign run      = state_q == RUN;
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_row_d   = res_row_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (size_ok) begin
          n_d     = bus.size;
          row_d   = '0;
          col_d   = '0;
          state_d = RUN;
        end else err_d = 1'b1;
      end
      RUN: begin
        col_d   = col_q + 1'b1;
        state_d = last_col ? FLUSH : RUN;
      end
      FLUSH: state_d = CAPT;
      CAPT: if (bus.proc_done) begin
        res_data_d  = bus.proc_out;
        res_row_d   = row_q;
        res_valid_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        done_d      = last_row;
        state_d     = last_row ? IDLE : RUN;
        row_d       = last_row ? row_q : row_q + 1'b1;
        col_d       = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Operand stage trails address issue by the one-cycle memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      retro_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_row_q   <= res_row_d;
      done_q      <= done_d;
      err_q       <= err_d;
      en_q        <= run;
      retro_q     <= run && col_q != '0;
    end
  end
  assign bus.err         = err_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.mat_addr    = run ? AW'(32'(row_q) * N + 32'(col_q)) : '0;
  assign bus.vec_addr    = run ? col_q : '0;
  assign bus.proc_enable = en_q;
  assign bus.proc_retro  = retro_q;
  assign bus.proc_A      = en_q ? bus.mat_data : '0;
  assign bus.proc_B      = en_q ? bus.vec_data : '0;
  assign bus.proc_prev   = bus.proc_out;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_row     = res_row_q;
endmodule

// File: doc/mxv_scheduler.md
# mxv_scheduler

Sequencing controller that drives one multiply-accumulate `processor` instance to compute a square matrix-vector product y = M·v, one dot product per row. It fetches operands from external matrix/vector memories (1-cycle synchronous read), feeds the processor one MAC per cycle with the correct `retro`/`prev` chaining, and captures each row's result. It presents each result on a ready/valid output port with backpressure and sits between the job-control logic and the processor datapath.

## Interface
- `N`, default 4: maximum matrix dimension.
- `DW`, default 16: data width, equal to the processor's data word width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; honoured only in IDLE.
- `size`  in  $clog2(N+1)  active dimension n; sampled with an accepted `start`.
- `err`  out  1  1-cycle pulse when `start` arrives in IDLE with n=0 or n>N.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  1-cycle pulse after the last row's result handshake.
- `mat_addr`  out  $clog2(N*N)  matrix read address = row*N + col.
- `mat_data`  in  DW  matrix read data, valid the cycle after `mat_addr`.
- `vec_addr`  out  $clog2(N)  vector read address = col.
- `vec_data`  in  DW  vector read data, valid the cycle after `vec_addr`.
- `proc_enable`, `proc_retro`  out  1  processor enable and accumulate select.
- `proc_A`, `proc_B`, `proc_prev`  out  DW  processor operands.
- `proc_out`  in  DW  processor registered result.
- `proc_done`  in  1  processor done flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  DW  dot product for row `res_row`.
- `res_row`  out  $clog2(N)  row index of `res_data`.

## Operation
- States: IDLE, RUN, FLUSH, CAPT, WAIT.
- IDLE: if `start` and 1≤`size`≤N, latch n, set row=0 and col=0, go to RUN. If `start` with an invalid size, pulse `err` and stay in IDLE.
- RUN: issue the addresses for (row, col). col increments each cycle. After col=n-1 is issued, go to FLUSH.
- FLUSH: no address is issued; the final MAC of the row executes. Go to CAPT.
- CAPT: `proc_done`=1 and `proc_out` holds the dot product. Load it into `res_data`/`res_row` and set `res_valid`. Go to WAIT.
- WAIT: hold the result until `res_ready`. On the handshake, clear `res_valid`:
  - if row<n-1: row++, col=0, go to RUN;
  - otherwise pulse `done` in the following cycle and go to IDLE.
- Operand stage (one cycle behind address issue): `proc_enable`=1, `proc_A`=`mat_data`, `proc_B`=`vec_data`, `proc_retro`=(delayed col≠0).
- `proc_prev` is wired straight from `proc_out`. `proc_enable` stays high continuously within a row, so the processor output always holds the previous partial sum.
- When `proc_enable`=0, drive `proc_A`, `proc_B` and `proc_retro` to 0. Addresses are 0 outside RUN.
- No arithmetic in this block. `res_data` is `proc_out` unmodified; the processor truncates products and sums to DW bits, so values wrap mod 2^DW.
- Only one row is in flight at a time, so the result slot is always empty at CAPT; no overwrite is possible.
- `start` while busy is ignored: no `err`, no effect.
- `rst` in any state: go to IDLE the next cycle, counters to 0, and discard the in-flight row. Any pending `done` pulse is dropped.

## Timing
- Reset values: all outputs 0.
- `start` accepted at cycle c; RUN occupies cycles c+1 … c+n.
- `proc_enable` is high during cycles c+2 … c+n+1, which is the FLUSH cycle.
- CAPT is at c+n+2. `res_valid` rises at c+n+3.
- Per-row period is n+3 cycles when `res_ready` is held at 1. Row r+1 RUN starts the cycle after row r's handshake.
- `done` is asserted the cycle after the final handshake, and `busy` is 0 in that same cycle.
- Under backpressure, `res_valid`, `res_data` and `res_row` stay stable until the handshake. No address or enable activity occurs during WAIT.

## Test plan
- n=2, M=[[1,2],[3,4]], v=[5,6], `res_ready`=1: `start` at cycle 0 → (row 0, 17) with `res_valid` at cycle 5, then (row 1, 39) at cycle 10. `done` at cycle 11.
- n=1, M=[[7]], v=[3]: result 21 at cycle 4. `proc_retro` is never 1. `done` at cycle 5.
- n=4 with `res_ready` held low for 10 cycles after the first `res_valid`: `res_data`/`res_row` stay stable, there is no address activity, row 1 RUN begins the cycle after `res_ready` rises, and all 4 results are correct.
- DW=16, n=2, row 0 = [0x00FF, 0x0001], v = [0x0101, 0x0001]: row 0 result is 0x0000 (0xFFFF+1 wraps).
- `size`=0 and `size`=5 (N=4): `err` pulses once each and `busy` stays 0. A `start` pulse mid-job is ignored and the results are unchanged.
- `rst` asserted during RUN of row 1: next cycle all outputs are 0, no `res_valid`, no `done`. A new job (n=2 case above) then produces 17 and 39.
